// File: rtl/mmio_arbiter_pkg.sv
// Shared MMIO types plus the arbiter state encoding and helper.
package mmio_arbiter_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      WIDTH_BYTE = 2'd0,
      WIDTH_HALF = 2'd1,
      WIDTH_WORD = 2'd2
   } write_width_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] value;
      write_width_t    width;
      logic            enable;
   } mem_write_control_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } mmio_arb_state_t;

   // Watchdog counter width: enough bits to hold the limit itself, never zero.
   function automatic int unsigned timeout_count_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Bundle of the two requester ports and the downstream MMIO port.
//
// Handshake: a requester raises control.enable (valid) and holds
// addr/value/width stable until it sees write_complete (done) high in the
// same cycle; that cycle is the transfer. It may present a new request the
// next cycle. Dropping enable before write_complete is an abort. The device
// side follows the same rule with dev_control / dev_write_complete.
interface mmio_arbiter_if;
   import mmio_arbiter_pkg::*;

   mem_write_control_t req0_control;
   logic               req0_write_complete;
   logic [XLEN-1:0]    req0_r_data;

   mem_write_control_t req1_control;
   logic               req1_write_complete;
   logic [XLEN-1:0]    req1_r_data;

   mem_write_control_t dev_control;
   logic               dev_write_complete;
   logic [XLEN-1:0]    dev_r_data;

   // Arbiter view.
   modport slave (
      input  req0_control, req1_control, dev_write_complete, dev_r_data,
      output req0_write_complete, req0_r_data,
      output req1_write_complete, req1_r_data,
      output dev_control
   );

   // Environment view: requesters and the device.
   modport master (
      output req0_control, req1_control, dev_write_complete, dev_r_data,
      input  req0_write_complete, req0_r_data,
      input  req1_write_complete, req1_r_data,
      input  dev_control
   );

endinterface

// File: rtl/mmio_timeout_counter.sv
// Saturating stall counter for the arbiter watchdog; LIMIT of 0 disables it.
module mmio_timeout_counter
   import mmio_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int unsigned CW = timeout_count_width(LIMIT);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] count;

   // Count stalled cycles, hold at the limit, clear on request; held at 0 when disabled.
   always_ff @(posedge clock) begin
      if (reset || clear || (LIMIT == 0)) begin
         count <= '0;
      end else if (count_en && (count != LIMIT_C)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (LIMIT != 0) && (count == LIMIT_C);

endmodule

// File: rtl/mmio_arbiter.sv
// Round-robin two-requester arbiter for the MMIO write port with a
// completion watchdog so a silent device cannot deadlock the hart.
module mmio_arbiter
   import mmio_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic            clock,
   input  logic            reset,
   mmio_arbiter_if.slave   bus,
   output logic            timeout_error,
   output logic [XLEN-1:0] timeout_addr,
   output mmio_arb_state_t dbg_state
);

   mmio_arb_state_t    state, state_next;
   logic               last_grant, last_grant_next;

   mem_write_control_t sel_ctrl;
   logic               sel;
   logic               granted;
   logic               other_en;
   logic               expired;
   logic               forced;
   logic               done;
   logic               abort;
   logic               cnt_clear;
   logic               cnt_en;

   mmio_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .expired  (expired)
   );

   // Decode the granted requester and its completion / abort / stall events.
   always_comb begin
      granted  = (state == GRANT0) || (state == GRANT1);
      sel      = (state == GRANT1);
      sel_ctrl = sel ? bus.req1_control : bus.req0_control;
      other_en = sel ? bus.req0_control.enable : bus.req1_control.enable;
      forced   = granted && sel_ctrl.enable && expired;
      done     = granted && sel_ctrl.enable && (bus.dev_write_complete || expired);
      abort    = granted && !sel_ctrl.enable;
      cnt_en   = granted && sel_ctrl.enable && !bus.dev_write_complete;
      cnt_clear = !granted || done || abort || (state_next != state);
   end

   // Next-state: round-robin on ties, back-to-back handoff on completion.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         IDLE: begin
            if (bus.req0_control.enable && bus.req1_control.enable) begin
               state_next = last_grant ? GRANT0 : GRANT1;
            end else if (bus.req0_control.enable) begin
               state_next = GRANT0;
            end else if (bus.req1_control.enable) begin
               state_next = GRANT1;
            end
         end
         GRANT0, GRANT1: begin
            if (abort) begin
               state_next = IDLE;
            end else if (done) begin
               last_grant_next = sel;
               if (other_en) begin
                  state_next = sel ? GRANT0 : GRANT1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Forward the granted requester, park the address in IDLE, gate all during reset.
   always_comb begin
      bus.dev_control         = '0;
      bus.req0_write_complete = 1'b0;
      bus.req1_write_complete = 1'b0;
      if (!reset) begin
         if (granted) begin
            bus.dev_control = sel_ctrl;
            if (forced) begin
               bus.dev_control.enable = 1'b0;
            end
            if (sel) begin
               bus.req1_write_complete = done;
            end else begin
               bus.req0_write_complete = done;
            end
         end else begin
            bus.dev_control.addr = last_grant ? bus.req1_control.addr
                                              : bus.req0_control.addr;
         end
      end
   end

   assign bus.req0_r_data = bus.dev_r_data;
   assign bus.req1_r_data = bus.dev_r_data;
   assign dbg_state       = state;

   // State, round-robin pointer and sticky watchdog report.
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         timeout_error <= 1'b0;
         timeout_addr  <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         if (forced) begin
            timeout_error <= 1'b1;
            if (!timeout_error) begin
               timeout_addr <= sel_ctrl.addr;
            end
         end
      end
   end

endmodule
